// File: rtl/risc_mem_defs.sv
// risc_mem_defs: shared state encodings, fault codes and defaults for the data memory responder
package risc_mem_defs;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_MISALIGN = 2'd1, ERR_RANGE = 2'd2} err_t;
    localparam int WAIT_CYCLES_DEFAULT = 2;
    function automatic err_t addr_check(input logic [31:0] addr, input int depth);
        if (addr[1:0] != 2'b00) return ERR_MISALIGN;
        if ({2'b00, addr[31:2]} >= 32'(depth)) return ERR_RANGE;
        return ERR_NONE;
    endfunction
endpackage

// File: rtl/byte_lane_ram.sv
// byte_lane_ram: single-port word RAM with per-byte write enables and a registered read
module byte_lane_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    input  logic [3:0]       we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        rdata <= mem[addr];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready load/store target that commits each access to a byte-lane RAM after fixed wait states
module data_mem_responder
    import risc_mem_defs::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
    parameter int IDX_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        rst_q, err_q, load_ok_q;
    logic        lat_write;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_wstrb;
    logic        idle, accept, commit, cur_write;
    logic [31:0] cur_addr, cur_wdata, ram_q;
    logic [3:0]  cur_wstrb, ram_we;
    err_t        cur_err;

    // In IDLE the live request drives the RAM so a zero-wait access can commit on its accept edge
    assign idle      = state == IDLE;
    assign accept    = req_valid && req_ready;
    assign cur_write = idle ? req_write : lat_write;
    assign cur_addr  = idle ? req_addr  : lat_addr;
    assign cur_wdata = idle ? req_wdata : lat_wdata;
    assign cur_wstrb = idle ? req_wstrb : lat_wstrb;
    assign cur_err   = addr_check(cur_addr, DEPTH_WORDS);
    assign commit    = (WAIT_CYCLES == 0) ? accept : (state == WAIT && cnt == 4'd0);
    assign ram_we    = (commit && cur_write && cur_err == ERR_NONE && !rst) ? cur_wstrb : 4'b0000;

    byte_lane_ram #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_ram (
        .clk   (clk),
        .addr  (cur_addr[IDX_W+1:2]),
        .we    (ram_we),
        .wdata (cur_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = accept ? ((WAIT_CYCLES == 0) ? RESP : WAIT) : IDLE;
            WAIT:    state_nx = (cnt == 4'd0) ? RESP : WAIT;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // The RAM keeps re-reading the latched word in RESP, so load data stays stable without a copy
    always_comb begin
        req_ready = idle && !rst_q;
        rsp_valid = state == RESP;
        rsp_rdata = (rsp_valid && load_ok_q) ? ram_q : 32'h0;
        rsp_err   = rsp_valid && err_q;
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            cnt       <= 4'd0;
            err_q     <= 1'b0;
            load_ok_q <= 1'b0;
        end else begin
            if (accept) cnt <= CNT_INIT;
            else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (commit) begin
                err_q     <= cur_err != ERR_NONE;
                load_ok_q <= !cur_write && cur_err == ERR_NONE;
            end else if (state == RESP && rsp_ready) begin
                err_q     <= 1'b0;
                load_ok_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk)
        if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
        end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed load/store traffic checked every cycle against a transaction-level memory model
module tb_data_mem_responder;
    localparam int DEPTH = 256;
    localparam int W     = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int          checks = 0, errors = 0, cyc = 0, acc = 0, got_lat = 0;
    logic        last_rst = 1'b1, act = 1'b0, chk_en = 1'b0, exp_err = 1'b0, got_err;
    logic [31:0] exp_rdata = '0, got_rdata;
    logic [31:0] mem_m [DEPTH];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W), .IDX_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        last_rst <= rst;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // A response is visible W cycles after the accept edge and holds until it is taken
    always @(negedge clk)
        if (chk_en) begin
            logic ev;
            ev = act && (cyc - acc >= W);
            chk("req_ready", 32'(req_ready), 32'(!act && !last_rst));
            chk("rsp_valid", 32'(rsp_valid), 32'(ev));
            chk("rsp_rdata", rsp_rdata, ev ? exp_rdata : 32'h0);
            chk("rsp_err", 32'(rsp_err), 32'(ev && exp_err));
        end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int stall, input bit abort);
        int n, k;
        logic e;
        req_write = w; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 20);
        if (!req_ready) begin
            chk("accept_timeout", 32'h0, 32'h1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        e = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
        exp_err   = e;
        exp_rdata = (!w && !e) ? mem_m[a[9:2]] : 32'h0;
        acc = cyc;
        act = 1'b1;
        if (abort) begin
            @(negedge clk); rst = 1'b1;
            @(posedge clk); #1;
            act = 1'b0; rst = 1'b0;
            return;
        end
        if (w && !e)
            for (int i = 0; i < 4; i++)
                if (s[i]) mem_m[a[9:2]][8*i +: 8] = d[8*i +: 8];
        n = 0; k = 0;
        while (n < 40 && !rsp_ready) begin
            @(negedge clk); n++;
            if (rsp_valid) begin
                if (k == 0) got_lat = cyc - acc;
                if (k >= stall) begin
                    got_rdata = rsp_rdata; got_err = rsp_err; rsp_ready = 1'b1;
                end
                k++;
            end
        end
        if (!rsp_ready) begin
            chk("response_timeout", 32'h0, 32'h1);
            act = 1'b0;
            return;
        end
        @(posedge clk); #1;
        act = 1'b0; rsp_ready = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        issue(1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 0);
        issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
        chk("store_latency", 32'(got_lat), 32'd2);
        chk("store_err", 32'(got_err), 32'h0);
        issue(0, 32'h10, 32'h0, 4'h0, 0, 0);
        chk("load_10", got_rdata, 32'hDEADBEEF);
        issue(1, 32'h20, 32'h11223344, 4'hF, 0, 0);
        issue(1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0);
        issue(0, 32'h20, 32'h0, 4'h0, 0, 0);
        chk("partial_strobe", got_rdata, 32'h11BB33DD);
        issue(0, 32'h6, 32'h0, 4'h0, 0, 0);
        chk("misalign_err", 32'(got_err), 32'h1);
        chk("misalign_rdata", got_rdata, 32'h0);
        issue(1, 32'h400, 32'h99999999, 4'hF, 0, 0);
        chk("range_err", 32'(got_err), 32'h1);
        issue(0, 32'h0, 32'h0, 4'h0, 0, 0);
        chk("word0_intact", got_rdata, 32'hCAFEF00D);
        issue(0, 32'h10, 32'h0, 4'h0, 5, 0);
        chk("backpressure_rdata", got_rdata, 32'hDEADBEEF);
        issue(1, 32'h30, 32'h12345678, 4'hF, 0, 0);
        issue(1, 32'h30, 32'h55555555, 4'hF, 0, 1);
        issue(0, 32'h30, 32'h0, 4'h0, 0, 0);
        chk("abort_keeps_old", got_rdata, 32'h12345678);
        issue(1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 0);
        chk("zero_strobe_err", 32'(got_err), 32'h0);
        issue(0, 32'h20, 32'h0, 4'h0, 0, 0);
        chk("zero_strobe_data", got_rdata, 32'h11BB33DD);
        issue(1, 32'h3FC, 32'h0BADC0DE, 4'hF, 0, 0);
        issue(0, 32'h3FC, 32'h0, 4'h0, 0, 0);
        chk("top_word", got_rdata, 32'h0BADC0DE);
        chk("top_word_err", 32'(got_err), 32'h0);
        issue(0, 32'h400, 32'h0, 4'h0, 0, 0);
        chk("load_range_err", 32'(got_err), 32'h1);
        issue(0, 32'hFFFFFFFC, 32'h0, 4'h0, 0, 0);
        chk("no_wrap_err", 32'(got_err), 32'h1);
        issue(1, 32'h3FD, 32'h1, 4'hF, 0, 0);
        issue(0, 32'h3FC, 32'h0, 4'h0, 0, 0);
        chk("top_word_after_fault", got_rdata, 32'h0BADC0DE);
        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
